// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: round-robin sharing of one file register and its data bus between requesters A and B
// Ports:
//   clk, rst (sync, active-low)
//   a_req/a_we/a_addr/a_wdata -> a_ack/a_rdata : requester A (B identical)
//   rf_we, rf_addr, rf_bus_oe, rf_wdata, rf_rdata : file register side
//   busy : high whenever a transaction is in flight
module reg_file_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int WR_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic                  rf_bus_oe,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  busy
);
  localparam int CW = WR_CYCLES > 1 ? $clog2(WR_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, DONE} state_t;
  state_t state;
  logic ptr, owner, we;
  logic [CW-1:0] cnt;
  logic gnt_b, g_we;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;
  // B wins when it is the only requester or when both request and ptr points at B
  always_comb begin
    gnt_b = b_req & (~a_req | ptr);
    g_we = gnt_b ? b_we : a_we;
    g_addr = gnt_b ? b_addr : a_addr;
    g_wdata = gnt_b ? b_wdata : a_wdata;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr <= 1'b0;
      owner <= 1'b0;
      we <= 1'b0;
      cnt <= '0;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      rf_we <= 1'b0;
      rf_bus_oe <= 1'b0;
      busy <= 1'b0;
      rf_addr <= '0;
      rf_wdata <= '0;
      a_rdata <= '0;
      b_rdata <= '0;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      case (state)
        IDLE: if (a_req | b_req) begin
          owner <= gnt_b;
          we <= g_we;
          rf_addr <= g_addr;
          rf_wdata <= g_wdata;
          rf_we <= g_we;
          rf_bus_oe <= g_we;
          cnt <= CW'(WR_CYCLES - 1);
          busy <= 1'b1;
          state <= ISSUE;
        end
        ISSUE: if (!we) begin
          state <= CAPTURE;
        end else if (cnt == '0) begin
          rf_we <= 1'b0;
          rf_bus_oe <= 1'b0;
          a_ack <= ~owner;
          b_ack <= owner;
          state <= DONE;
        end else begin
          cnt <= cnt - 1'b1;
        end
        CAPTURE: begin
          if (owner) b_rdata <= rf_rdata;
          else a_rdata <= rf_rdata;
          a_ack <= ~owner;
          b_ack <= owner;
          state <= DONE;
        end
        DONE: begin
          ptr <= ~owner;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
